// File: rtl/sfx_audio_mux.sv
// -----------------------------------------------------------------------------
// sfx_audio_mux
//
// Final audio stage behind the background-music player. It passes the music
// square wave through to the speaker pin and overlays short sound-effect tones
// (coin, jump, crash) on top of it. It also applies mute and counts completed
// music passes. Once a crash effect has finished playing, all audio stays
// silent until reset (game over).
//
// Ports:
//   clk             in   1  system clock
//   rst             in   1  synchronous, active-high reset
//   music_speaker   in   1  square wave from the music player
//   music_finished  in   1  high while the player is past its last note
//   sfx_coin        in   1  one-cycle event pulse, priority 1
//   sfx_jump        in   1  one-cycle event pulse, priority 2
//   sfx_crash       in   1  one-cycle event pulse, priority 3
//   mute            in   1  level; forces the speaker low while high
//   speaker         out  1  registered speaker pin drive
//   sfx_active      out  2  current effect: 0 none, 1 coin, 2 jump, 3 crash
//   halted          out  1  high once the crash effect has completed
//   loop_count      out  8  completed music passes, wraps modulo 256
// -----------------------------------------------------------------------------
module sfx_audio_mux #(
  parameter int EFFECT_LEN_CYC = 2500000,
  parameter int HALF_PER_COIN  = 12500,
  parameter int HALF_PER_JUMP  = 25000,
  parameter int HALF_PER_CRASH = 50000,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       music_speaker,
  input  logic       music_finished,
  input  logic       sfx_coin,
  input  logic       sfx_jump,
  input  logic       sfx_crash,
  input  logic       mute,
  output logic       speaker,
  output logic [1:0] sfx_active,
  output logic       halted,
  output logic [7:0] loop_count
);

  typedef enum logic [1:0] {
    ST_MUSIC = 2'd0,
    ST_SFX   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_COIN  = 2'd1;
  localparam logic [1:0] CODE_JUMP  = 2'd2;
  localparam logic [1:0] CODE_CRASH = 2'd3;

  // Counters count down to zero, so they are loaded with "length minus one".
  localparam logic [CNT_W-1:0] LEN_LAST        = CNT_W'(EFFECT_LEN_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_COIN_LAST  = CNT_W'(HALF_PER_COIN - 1);
  localparam logic [CNT_W-1:0] HALF_JUMP_LAST  = CNT_W'(HALF_PER_JUMP - 1);
  localparam logic [CNT_W-1:0] HALF_CRASH_LAST = CNT_W'(HALF_PER_CRASH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_sfx_active;
  logic [1:0]       w_sfx_active_next;
  logic [CNT_W-1:0] r_len_cnt;
  logic [CNT_W-1:0] w_len_cnt_next;
  logic [CNT_W-1:0] r_half_cnt;
  logic [CNT_W-1:0] w_half_cnt_next;
  logic             r_tone;
  logic             w_tone_next;
  logic             r_speaker;
  logic             w_speaker_next;
  logic             r_fin_d;
  logic [7:0]       r_loop_count;

  logic [1:0]       w_req_code;
  logic             w_accept;
  logic             w_last_cycle;

  // Reload value of the half-period counter for a given effect code.
  function automatic logic [CNT_W-1:0] half_last(input logic [1:0] code);
    case (code)
      CODE_CRASH: half_last = HALF_CRASH_LAST;
      CODE_JUMP:  half_last = HALF_JUMP_LAST;
      default:    half_last = HALF_COIN_LAST;
    endcase
  endfunction

  // Highest-priority pulse wins; lower simultaneous pulses are simply dropped.
  always_comb begin
    w_req_code = CODE_NONE;
    if (sfx_crash)      w_req_code = CODE_CRASH;
    else if (sfx_jump)  w_req_code = CODE_JUMP;
    else if (sfx_coin)  w_req_code = CODE_COIN;
  end

  // While an effect plays only a strictly higher code may restart it, so a
  // repeated or lower event never extends the running effect.
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      ST_MUSIC: w_accept = (w_req_code != CODE_NONE);
      ST_SFX:   w_accept = (w_req_code > r_sfx_active);
      default:  w_accept = 1'b0;
    endcase
  end

  assign w_last_cycle = (r_len_cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_MUSIC;
    else     r_state <= w_state_next;
  end

  // Next-state logic. An accepted request on the last effect cycle wins over
  // the exit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_MUSIC: begin
        if (w_accept) w_state_next = ST_SFX;
      end
      ST_SFX: begin
        if (w_accept)          w_state_next = ST_SFX;
        else if (w_last_cycle) w_state_next = (r_sfx_active == CODE_CRASH) ? ST_HALT : ST_MUSIC;
      end
      ST_HALT:  w_state_next = ST_HALT;
      default:  w_state_next = ST_MUSIC;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    w_speaker_next    = 1'b0;
    w_sfx_active_next = r_sfx_active;
    w_len_cnt_next    = r_len_cnt;
    w_half_cnt_next   = r_half_cnt;
    w_tone_next       = r_tone;
    case (r_state)
      ST_MUSIC: begin
        w_speaker_next = music_speaker & ~mute;
      end
      ST_SFX: begin
        w_speaker_next = r_tone & ~mute;
        if (r_half_cnt == '0) begin
          w_tone_next     = ~r_tone;
          w_half_cnt_next = half_last(r_sfx_active);
        end else begin
          w_half_cnt_next = r_half_cnt - CNT_ONE;
        end
        if (w_last_cycle) begin
          w_sfx_active_next = CODE_NONE;
        end else begin
          w_len_cnt_next = r_len_cnt - CNT_ONE;
        end
      end
      default: begin
        w_speaker_next    = 1'b0;
        w_sfx_active_next = CODE_NONE;
      end
    endcase
    // Entering or restarting an effect overrides the per-cycle update above.
    if (w_accept) begin
      w_sfx_active_next = w_req_code;
      w_len_cnt_next    = LEN_LAST;
      w_half_cnt_next   = half_last(w_req_code);
      w_tone_next       = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sfx_active <= CODE_NONE;
      r_len_cnt    <= '0;
      r_half_cnt   <= '0;
      r_tone       <= 1'b0;
      r_speaker    <= 1'b0;
    end else begin
      r_sfx_active <= w_sfx_active_next;
      r_len_cnt    <= w_len_cnt_next;
      r_half_cnt   <= w_half_cnt_next;
      r_tone       <= w_tone_next;
      r_speaker    <= w_speaker_next;
    end
  end

  // Music pass counter: rising edge of music_finished, in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fin_d      <= 1'b0;
      r_loop_count <= 8'd0;
    end else begin
      r_fin_d <= music_finished;
      if (music_finished && !r_fin_d) r_loop_count <= r_loop_count + 8'd1;
    end
  end

  assign speaker    = r_speaker;
  assign sfx_active = r_sfx_active;
  assign halted     = (r_state == ST_HALT);
  assign loop_count = r_loop_count;

endmodule

// File: tb/tb_sfx_audio_mux.sv
// -----------------------------------------------------------------------------
// tb_sfx_audio_mux
//
// Scoreboard bench for sfx_audio_mux with short effect parameters
// (effect 20 cycles, half-periods coin 2, jump 3, crash 5). The stimulus
// process drives directed vectors and queues the expected output values
// tagged with the cycle at which they must appear; a monitor samples the DUT
// on the falling edge and retires every entry due in that cycle.
// -----------------------------------------------------------------------------
module tb_sfx_audio_mux;

  localparam logic [3:0] M_SPK  = 4'b0001;
  localparam logic [3:0] M_ACT  = 4'b0010;
  localparam logic [3:0] M_HALT = 4'b0100;
  localparam logic [3:0] M_LC   = 4'b1000;
  localparam logic [3:0] M_ALL  = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic       music_speaker;
  logic       music_finished;
  logic       sfx_coin;
  logic       sfx_jump;
  logic       sfx_crash;
  logic       mute;
  logic       speaker;
  logic [1:0] sfx_active;
  logic       halted;
  logic [7:0] loop_count;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    logic [3:0] mask;
    logic       spk;
    logic [1:0] act;
    logic       halt;
    logic [7:0] lc;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];

  // Passthrough vectors: music_speaker, mute, and the speaker value expected
  // one cycle later.
  bit pt_ms [12] = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0};
  bit pt_mu [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  bit pt_exp[12] = '{1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0};

  sfx_audio_mux #(
    .EFFECT_LEN_CYC(20),
    .HALF_PER_COIN (2),
    .HALF_PER_JUMP (3),
    .HALF_PER_CRASH(5),
    .CNT_W         (24)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .music_speaker (music_speaker),
    .music_finished(music_finished),
    .sfx_coin      (sfx_coin),
    .sfx_jump      (sfx_jump),
    .sfx_crash     (sfx_crash),
    .mute          (mute),
    .speaker       (speaker),
    .sfx_active    (sfx_active),
    .halted        (halted),
    .loop_count    (loop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int due, input logic [3:0] mask, input logic spk,
                      input logic [1:0] act, input logic halt, input logic [7:0] lc,
                      input string name);
    exp_t e;
    e.due  = due;
    e.mask = mask;
    e.spk  = spk;
    e.act  = act;
    e.halt = halt;
    e.lc   = lc;
    sb_q.push_back(e);
    nm_q.push_back(name);
  endtask

  // Effect starting its first cycle at 'start': sfx_active = code for nact
  // cycles, and the speaker shows the tone (high for h cycles, low for h)
  // one cycle later for nspk cycles.
  task automatic expect_effect(input int start, input int h, input logic [1:0] code,
                               input int nact, input int nspk);
    for (int k = 0; k < nact; k++)
      push(start + k, M_ACT | M_HALT, 1'b0, code, 1'b0, 8'd0, "effect_active");
    for (int e = 0; e < nspk; e++)
      push(start + 1 + e, M_SPK, ((e / h) % 2) == 0, 2'd0, 1'b0, 8'd0, "effect_tone");
  endtask

  // One music_finished pulse; loop_count must read after-1 now and 'after'
  // once the pulse and the following low time are over.
  task automatic fin_pulse(input int hi, input int lo, input logic [7:0] after);
    push(cyc, M_LC, 1'b0, 2'd0, 1'b0, after - 8'd1, "loop_before");
    push(cyc + hi + lo, M_LC, 1'b0, 2'd0, 1'b0, after, "loop_after");
    music_finished = 1'b1;
    repeat (hi) tick();
    music_finished = 1'b0;
    repeat (lo) tick();
  endtask

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        if (sb_q[i].mask[0]) begin
          checks++;
          if (speaker !== sb_q[i].spk) begin
            errors++;
            $display("FAIL %s speaker cyc=%0d got %0b want %0b", nm_q[i], cyc, speaker, sb_q[i].spk);
          end
        end
        if (sb_q[i].mask[1]) begin
          checks++;
          if (sfx_active !== sb_q[i].act) begin
            errors++;
            $display("FAIL %s sfx_active cyc=%0d got %0d want %0d", nm_q[i], cyc, sfx_active, sb_q[i].act);
          end
        end
        if (sb_q[i].mask[2]) begin
          checks++;
          if (halted !== sb_q[i].halt) begin
            errors++;
            $display("FAIL %s halted cyc=%0d got %0b want %0b", nm_q[i], cyc, halted, sb_q[i].halt);
          end
        end
        if (sb_q[i].mask[3]) begin
          checks++;
          if (loop_count !== sb_q[i].lc) begin
            errors++;
            $display("FAIL %s loop_count cyc=%0d got %0d want %0d", nm_q[i], cyc, loop_count, sb_q[i].lc);
          end
        end
        sb_q.delete(i);
        nm_q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst            = 1'b1;
    music_speaker  = 1'b0;
    music_finished = 1'b0;
    sfx_coin       = 1'b0;
    sfx_jump       = 1'b0;
    sfx_crash      = 1'b0;
    mute           = 1'b0;
    repeat (3) tick();
    push(cyc + 1, M_ALL, 1'b0, 2'd0, 1'b0, 8'd0, "reset");
    tick();
    rst = 1'b0;

    // Music passthrough with one-cycle latency, including mute in MUSIC.
    for (int i = 0; i < 12; i++) begin
      music_speaker = pt_ms[i];
      mute          = pt_mu[i];
      push(cyc + 1, M_SPK | M_ACT | M_HALT, pt_exp[i], 2'd0, 1'b0, 8'd0, "passthrough");
      tick();
    end
    mute          = 1'b0;
    music_speaker = 1'b1;
    repeat (2) tick();

    // Coin effect: 1,1,0,0,... for 20 cycles while music stays high.
    t = cyc;
    sfx_coin = 1'b1;
    expect_effect(t + 1, 2, 2'd1, 20, 20);
    push(t + 21, M_ACT | M_HALT, 1'b0, 2'd0, 1'b0, 8'd0, "coin_end");
    push(t + 22, M_SPK, 1'b1, 2'd0, 1'b0, 8'd0, "coin_music_back");
    tick();
    sfx_coin = 1'b0;
    repeat (22) tick();

    // Coin then jump preempts at t+5; a later coin is ignored.
    t = cyc;
    sfx_coin = 1'b1;
    expect_effect(t + 1, 2, 2'd1, 5, 5);
    expect_effect(t + 6, 3, 2'd2, 20, 20);
    push(t + 26, M_ACT, 1'b0, 2'd0, 1'b0, 8'd0, "jump_end");
    push(t + 27, M_SPK, 1'b1, 2'd0, 1'b0, 8'd0, "jump_music_back");
    tick();
    sfx_coin = 1'b0;
    repeat (4) tick();
    sfx_jump = 1'b1;
    tick();
    sfx_jump = 1'b0;
    repeat (2) tick();
    sfx_coin = 1'b1;
    tick();
    sfx_coin = 1'b0;
    repeat (20) tick();

    // Jump on the last coin cycle wins over the exit; a coin on the last
    // jump cycle does not extend it.
    t = cyc;
    sfx_coin = 1'b1;
    expect_effect(t + 1, 2, 2'd1, 20, 20);
    expect_effect(t + 21, 3, 2'd2, 20, 20);
    push(t + 41, M_ACT | M_HALT, 1'b0, 2'd0, 1'b0, 8'd0, "late_jump_end");
    tick();
    sfx_coin = 1'b0;
    repeat (19) tick();
    sfx_jump = 1'b1;
    tick();
    sfx_jump = 1'b0;
    repeat (19) tick();
    sfx_coin = 1'b1;
    tick();
    sfx_coin = 1'b0;
    repeat (2) tick();

    // Mute during a coin effect: speaker low for the muted window only.
    t = cyc;
    sfx_coin = 1'b1;
    expect_effect(t + 1, 2, 2'd1, 20, 0);
    for (int e = 0; e < 20; e++) begin
      if (t + 2 + e >= t + 6 && t + 2 + e <= t + 10)
        push(t + 2 + e, M_SPK, 1'b0, 2'd0, 1'b0, 8'd0, "mute_silent");
      else
        push(t + 2 + e, M_SPK, ((e / 2) % 2) == 0, 2'd0, 1'b0, 8'd0, "mute_tone");
    end
    push(t + 21, M_ACT, 1'b0, 2'd0, 1'b0, 8'd0, "mute_effect_end");
    push(t + 22, M_SPK, 1'b1, 2'd0, 1'b0, 8'd0, "mute_music_back");
    tick();
    sfx_coin = 1'b0;
    repeat (4) tick();
    mute = 1'b1;
    repeat (5) tick();
    mute = 1'b0;
    repeat (13) tick();

    // Loop counting: three 3-cycle pulses, then a 10-cycle hold.
    fin_pulse(3, 2, 8'd1);
    fin_pulse(3, 2, 8'd2);
    fin_pulse(3, 2, 8'd3);
    fin_pulse(10, 2, 8'd4);

    // Coin and crash together: crash wins, then game over.
    t = cyc;
    sfx_coin  = 1'b1;
    sfx_crash = 1'b1;
    expect_effect(t + 1, 5, 2'd3, 20, 20);
    push(t + 21, M_ACT | M_HALT, 1'b0, 2'd0, 1'b1, 8'd0, "halt_enter");
    for (int k = 22; k <= 40; k++)
      push(t + k, M_SPK | M_ACT | M_HALT, 1'b0, 2'd0, 1'b1, 8'd0, "halt_hold");
    tick();
    sfx_coin  = 1'b0;
    sfx_crash = 1'b0;
    repeat (20) tick();
    for (int k = 0; k < 19; k++) begin
      music_speaker = k[0];
      sfx_coin      = (k == 2);
      sfx_jump      = (k == 5);
      sfx_crash     = (k == 8);
      tick();
    end
    sfx_coin      = 1'b0;
    sfx_jump      = 1'b0;
    sfx_crash     = 1'b0;
    music_speaker = 1'b1;
    fin_pulse(1, 1, 8'd5);

    // Reset leaves HALT and clears everything.
    push(cyc + 1, M_ALL, 1'b0, 2'd0, 1'b0, 8'd0, "reset_from_halt");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(cyc + 1, M_SPK | M_HALT, 1'b1, 2'd0, 1'b0, 8'd0, "music_after_reset");
    tick();

    // 256 edges from zero wrap the counter back to zero.
    for (int i = 1; i <= 256; i++) fin_pulse(1, 1, 8'(i));

    repeat (3) tick();
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfx_audio_mux.md
Name: sfx_audio_mux

Overview:
- Final audio stage sitting directly downstream of the background-music player.
- Consumes the player's square-wave `speaker` bit and `finished` flag, plus one-cycle game event pulses (coin, jump, crash).
- Overlays prioritised sound-effect tones on the music, applies mute, and drives the board speaker pin.
- After a crash effect completes, silences all audio until reset (game over).

Parameters:
- EFFECT_LEN_CYC, 2500000 — duration of every sound effect in clk cycles (100 ms @ 25 MHz); min 2.
- HALF_PER_COIN, 12500 — half-period of the coin tone in cycles (1 kHz); min 1.
- HALF_PER_JUMP, 25000 — half-period of the jump tone (500 Hz); min 1.
- HALF_PER_CRASH, 50000 — half-period of the crash tone (250 Hz); min 1.
- CNT_W, 24 — width of the length and half-period counters; must hold every parameter above.

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- music_speaker  in  1  square wave from the music player
- music_finished  in  1  high while the music player is past its last note
- sfx_coin  in  1  one-cycle event pulse
- sfx_jump  in  1  one-cycle event pulse
- sfx_crash  in  1  one-cycle event pulse
- mute  in  1  level; forces speaker low while high
- speaker  out  1  registered speaker pin drive
- sfx_active  out  2  current effect: 0 none, 1 coin, 2 jump, 3 crash
- halted  out  1  high in HALT state
- loop_count  out  8  number of completed music passes, wraps 255→0

Behaviour:
- Reset: all outputs reset to 0, state MUSIC, all counters 0, the music_finished edge register 0, and the tone bit 0. Reset has priority over everything, mid-effect included.
- Request priority: crash (3) > jump (2) > coin (1). With simultaneous pulses, the highest one wins and the others are dropped.
- State MUSIC:
  - Next speaker = music_speaker & ~mute. This is a 1-cycle latency.
  - Any request → state SFX, sfx_active = request code, len_cnt = EFFECT_LEN_CYC-1, half_cnt = HALF_PER_x-1, tone = 1.
- State SFX, each cycle:
  - Speaker = tone & ~mute.
  - If half_cnt == 0, toggle tone and reload half_cnt = HALF_PER_x-1; otherwise decrement half_cnt.
  - len_cnt decrements. The cycle with len_cnt == 0 is the last effect cycle. Next state is HALT if sfx_active == 3, else MUSIC; sfx_active → 0.
  - Speaker is therefore driven by the effect for exactly EFFECT_LEN_CYC cycles.
- Preemption in SFX: a request with a strictly higher code than sfx_active restarts the effect as on entry (new code, counters reloaded, tone = 1). Equal or lower requests are ignored; the effect is not extended.
- A request arriving on the last effect cycle follows the same rule. If it is accepted, the preemption wins over the exit.
- State HALT: speaker = 0, halted = 1, sfx_active = 0, all requests ignored. Exits only via rst.
- loop_count:
  - Increments by 1 on every rising edge of music_finished (registered edge detect), in every state including HALT.
  - Wraps modulo 256.
- Mute:
  - Affects speaker only. The FSM, counters and loop_count run unchanged.
  - Mute takes effect on the speaker register one cycle after mute changes.

Test Plan (params EFFECT_LEN_CYC=20, HALF_PER_COIN=2, HALF_PER_JUMP=3, HALF_PER_CRASH=5):
- Reset, then toggle music_speaker each cycle with no events → speaker equals music_speaker delayed 1 cycle; sfx_active = 0, halted = 0.
- Coin pulse at cycle T → sfx_active = 1 from T+1. Speaker pattern 1,1,0,0,1,1,… for exactly 20 cycles, then back to music passthrough; music_speaker is ignored during the effect.
- Coin at T, jump at T+5 → sfx_active 1→2 at T+6, jump pattern (3 high / 3 low) runs 20 cycles from T+6. A further coin at T+8 changes nothing.
- Simultaneous coin + crash pulse → sfx_active = 3 with a 5/5 tone for 20 cycles, then halted = 1 and speaker = 0. Further events and music_speaker activity have no effect until rst, which returns all outputs to 0 and the state to MUSIC.
- Pulse music_finished high for 3 cycles, three separate times → loop_count = 3. Hold it high for 10 cycles → only +1. 256 edges from 0 → wraps to 0.
- mute = 1 during a coin effect → speaker 0 from the next cycle while sfx_active stays 1. Effect still ends at 20 cycles; releasing mute restores the current source 1 cycle later.
